// File: rtl/jtdsp16_pkg.sv
// Shared constants and state encoding for the JTDSP16 do-loop sequencer.
package jtdsp16_pkg;

    localparam int DO_NW   = 4;
    localparam int DO_KW   = 11;
    localparam int DO_MAXN = 15;

    typedef enum logic {
        IDLE = 1'b0,
        LOOP = 1'b1
    } do_state_e;

endpackage

// File: rtl/jtdsp16_do_ctr.sv
// Combined body-index / iteration counter: load, wrap-to-1 on body end, terminal detect.
module jtdsp16_do_ctr
    import jtdsp16_pkg::*;
#(
    parameter int NW = DO_NW,
    parameter int KW = DO_KW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          adv,
    input  logic [KW-1:0] load_k,
    input  logic [NW-1:0] last_n,
    output logic [NW-1:0] pc,
    output logic [KW-1:0] cnt,
    output logic          term
);

    logic [NW-1:0] pc_q,  pc_d;
    logic [KW-1:0] cnt_q, cnt_d;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        if (load) begin
            pc_d  = NW'(1);
            cnt_d = load_k;
        end else if (adv) begin
            if (pc_q < last_n) begin
                pc_d = pc_q + NW'(1);
            end else if (cnt_q > KW'(1)) begin
                pc_d  = NW'(1);
                cnt_d = cnt_q - KW'(1);
            end else begin
                pc_d  = '0;
                cnt_d = '0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= '0;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
        end
    end

    assign pc   = pc_q;
    assign cnt  = cnt_q;
    assign term = (pc_q == last_n) && (cnt_q == KW'(1));

endmodule

// File: rtl/jtdsp16_do_ctrl.sv
// Do-loop sequencer feeding the ROM address unit with DO/REDO loop strobes.
// Optional sticky misuse flag do_err when JTDSP16_DO_ERR_EN is defined.
module jtdsp16_do_ctrl
    import jtdsp16_pkg::*;
#(
    parameter int NW = DO_NW,
    parameter int KW = DO_KW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          pc_halt,
    input  logic          do_en,
    input  logic          redo_en,
    input  logic [NW-1:0] ni_field,
    input  logic [6:0]    k_imm,
    input  logic          k_sel,
    input  logic [KW-1:0] k_reg,
    output logic          do_start,
    output logic          do_redo,
    output logic          do_save,
    output logic          do_short,
    output logic          do_out,
    output logic [NW-1:0] do_pc,
    output logic [KW-1:0] do_data,
    output logic          do_busy
`ifdef JTDSP16_DO_ERR_EN
    ,
    output logic          do_err
`endif
);

    do_state_e     state_q, state_d;
    logic [NW-1:0] last_n_q, last_n_d;
    logic [KW-1:0] k_val;
    logic          idle, busy;
    logic          do_acc, redo_acc, adv, term;

    assign k_val = k_sel ? k_reg : {{(KW-7){1'b0}}, k_imm};
    assign idle  = (state_q == IDLE);
    assign busy  = (state_q == LOOP);

    // do_en has priority: a DO that turns out to be a NOP also blocks a REDO.
    assign do_acc   = cen && idle && do_en && (ni_field != '0) && (k_val != '0);
    assign redo_acc = cen && idle && !do_en && redo_en && (last_n_q != '0) && (k_val != '0);
    assign adv      = cen && busy && !pc_halt;

    jtdsp16_do_ctr #(.NW(NW), .KW(KW)) u_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (do_acc || redo_acc),
        .adv    (adv),
        .load_k (k_val),
        .last_n (last_n_q),
        .pc     (do_pc),
        .cnt    (do_data),
        .term   (term)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_n_q <= '0;
        end else begin
            state_q  <= state_d;
            last_n_q <= last_n_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_n_d = do_acc ? ni_field : last_n_q;
        case (state_q)
            IDLE:    if (do_acc || redo_acc) state_d = LOOP;
            LOOP:    if (adv && term)        state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        do_start = do_acc || redo_acc;
        do_save  = do_acc;
        do_redo  = redo_acc;
        do_out   = adv && term;
        do_busy  = busy;
        do_short = busy && (last_n_q == NW'(1));
    end

`ifdef JTDSP16_DO_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (cen && busy && (do_en || redo_en))                      err_d = 1'b1;
        if (cen && do_en && (ni_field == '0))                       err_d = 1'b1;
        if (cen && !do_en && redo_en && (last_n_q == '0))           err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign do_err = err_q;
`endif

endmodule

// File: doc/jtdsp16_do_ctrl.md
Name: jtdsp16_do_ctrl

Overview:
- Do-loop sequencer; sits directly upstream of the ROM address unit.
- Decodes the outcome of DO/REDO instructions into the loop-control strobes the address unit consumes: do_start, do_redo, do_save, do_short, do_out, do_pc and do_data.
- Tracks instruction index within the loop body and remaining iteration count.
- Exposes the live count as the readable loop-count register.

Parameters:
- NW, 4, width of instruction-count field; max body length 2^NW-1 = 15.
- KW, 11, width of iteration counter and do_data.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- cen  in  1  clock enable; all state advances only when high
- pc_halt  in  1  pipeline stall; freezes index and count
- do_en  in  1  DO instruction decoded this cycle
- redo_en  in  1  REDO instruction decoded this cycle
- ni_field  in  NW  loop body length N from instruction
- k_imm  in  7  immediate iteration count
- k_sel  in  1  1: count from k_reg; 0: from k_imm (zero-extended)
- k_reg  in  KW  register-sourced iteration count
- do_start  out  1  pulse: loop entered, ROM address taken from cache base
- do_redo  out  1  pulse with do_start for REDO (base not re-saved)
- do_save  out  1  pulse: capture loop base from current PC
- do_short  out  1  level: active loop has N==1
- do_out  out  1  pulse: last instruction of final iteration
- do_pc  out  NW  body index, 1..N
- do_data  out  KW  remaining iterations, including the current one
- do_busy  out  1  loop active

Behaviour:
- Reset (rst_n low): state IDLE.
  - Outputs zero: do_pc=0, do_data=0, all strobes 0, do_short=0, do_busy=0.
  - Latched N: last_n=0.
- States:
  - IDLE: in this state, on cen && do_en && N!=0 && K!=0:
    - Same cycle, combinational: do_start=1, do_save=1.
    - Registered: last_n<=N, do_pc<=1, do_data<=K, go to LOOP.
  - REDO, same condition but with redo_en && last_n!=0 && K!=0:
    - Same cycle, combinational: do_start=1, do_redo=1, do_save=0.
    - Registered: do_pc<=1, do_data<=K, go to LOOP.
    - Body length reuses last_n.
  - LOOP, each cen && !pc_halt:
    - If do_pc<last_n: do_pc++.
    - Else if do_data>1: do_pc<=1, do_data--.
    - Else (do_pc==last_n && do_data==1): do_out=1 combinational this cycle. Registered: go to IDLE, do_pc<=0, do_data<=0.
- Timing:
  - Strobes are combinational from registered state plus decoded inputs, valid in the cycle they are consumed.
  - A body of N instructions repeated K times yields exactly N*K LOOP cycles (excluding halts). do_out is asserted on the last of these.
- Stalls: pc_halt high in LOOP holds do_pc, do_data and do_out low. do_out is asserted only on an advancing cycle.
- do_short = do_busy && last_n==1.
- K=0 or N=0: instruction treated as NOP. No strobes, state unchanged.
- do_en and redo_en together: do_en wins.
- do_en or redo_en while in LOOP: ignored. The loop continues; no strobe is generated.
- Arithmetic:
  - k_imm is zero-extended to KW.
  - The counter never wraps; the decrement is gated by do_data>1.
- Reset mid-loop returns to IDLE immediately. No do_out is issued.
- last_n persists across loops until reset; REDO after reset is a NOP.

Optional Feature:
- Macro: JTDSP16_DO_ERR_EN.
- With the macro: an extra output do_err (1 bit) is added.
  - Sticky, cleared only by reset.
  - Set on any cen cycle where do_en or redo_en is high while in LOOP.
  - Also set on a DO with N==0, or a REDO with last_n==0.
- Without the macro: no port and no logic; the same cases are silently ignored, as described above.

Decomposition:
- Shared package jtdsp16_pkg holds:
  - Constants DO_NW=4 and DO_KW=11.
  - State encoding: IDLE, LOOP.
  - DO_MAXN=15.
- One natural sub-module: jtdsp16_do_ctr.
  - Combined body-index/iteration counter with load, wrap-to-1 and terminal detect.
  - Emits the terminal condition for do_out.

Test Plan:
- DO, N=3, k_imm=2, no halts:
  - do_start/do_save on the DO cycle.
  - do_pc sequence 1,2,3,1,2,3.
  - do_data 2,2,2,1,1,1.
  - do_out on the 6th LOOP cycle, then IDLE.
- DO, N=1, K=4 -> do_short=1 for 4 cycles, do_pc stays 1, do_out on cycle 4.
- REDO with k_sel=1, k_reg=5 after the previous N=3 loop -> do_start+do_redo, do_save=0, 15 LOOP cycles, do_out on the last.
- pc_halt high for 2 cycles at do_pc=2, N=3, K=1 -> do_pc holds at 2, no do_out during the halt, loop finishes 2 cycles late.
- Nested DO issued at do_pc=1 in LOOP -> ignored, loop completes normally; with JTDSP16_DO_ERR_EN, do_err=1 and stays set.
- rst_n low at do_pc=2, do_data=3 -> all outputs 0 asynchronously; a following REDO is a NOP; a DO with K=0 is a NOP.
